rc_link_monitor: RTL

RC_LINK_MONITOR -- requirements
Module: rc_link_monitor

---
 rtl/drone_pkg.sv | 30 +++
 rtl/link_watchdog.sv | 29 ++
 rtl/rc_link_monitor.sv | 113 +++++++++++
 3 files changed

// File: rtl/drone_pkg.sv
// Shared types for the drone control slice: RC link monitor states, flight-state
// FSM states and a small saturating-increment helper used by the counters.
package drone_pkg;

    localparam logic [1:0] ST_NO_LINK  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;
    localparam logic [1:0] ST_FAILSAFE = 2'd3;

    typedef enum logic [1:0] {
        NO_LINK  = ST_NO_LINK,
        ACQUIRE  = ST_ACQUIRE,
        LOCKED   = ST_LOCKED,
        FAILSAFE = ST_FAILSAFE
    } link_state_t;

    typedef enum logic [2:0] {
        FLT_DISARMED = 3'd0,
        FLT_ARMED    = 3'd1,
        FLT_TAKEOFF  = 3'd2,
        FLT_FLYING   = 3'd3,
        FLT_LANDING  = 3'd4,
        FLT_FAILSAFE = 3'd5
    } flight_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/link_watchdog.sv
// Frame watchdog: counts clk cycles since the last kick, saturating at TIMEOUT_CYCLES;
// timeout is asserted while the count sits at the limit.
module link_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic kick,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (kick) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + CNT_W'(1);
        end
    end

    assign timeout = (count == LIMIT);

endmodule

// File: rtl/rc_link_monitor.sv
// RC receiver link monitor: acquires lock after consecutive good frames, drops to
// failsafe on frame loss or a burst of bad frames, and counts CRC errors.
module rc_link_monitor
    import drone_pkg::*;
#(
    parameter int ACQUIRE_FRAMES = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int BAD_LIMIT      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_valid,
    input  logic       frame_crc_ok,
    output logic       reciverenable,
    output logic       failsafe,
    output logic [1:0] link_state,
    output logic [7:0] frame_err_cnt
);

    localparam logic [7:0] ACQ_TARGET = 8'(ACQUIRE_FRAMES);
    localparam logic [7:0] BAD_TARGET = 8'(BAD_LIMIT);

    link_state_t state, state_nxt;
    logic [7:0]  good_cnt, good_cnt_nxt;
    logic [7:0]  bad_cnt, bad_cnt_nxt;
    logic        good_frame, bad_frame;
    logic        wd_timeout, timeout_evt;

    assign good_frame = frame_valid && frame_crc_ok;
    assign bad_frame  = frame_valid && !frame_crc_ok;

    link_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .kick   (good_frame),
        .timeout(wd_timeout)
    );

    // A good frame on the cycle the watchdog expires keeps the link alive.
    assign timeout_evt = wd_timeout && !good_frame;

    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        bad_cnt_nxt  = bad_cnt;
        case (state)
            NO_LINK: begin
                if (good_frame) begin
                    state_nxt    = ACQUIRE;
                    good_cnt_nxt = 8'd1;
                end
            end
            ACQUIRE: begin
                if (bad_frame || timeout_evt) begin
                    state_nxt    = NO_LINK;
                    good_cnt_nxt = '0;
                end else if (good_frame) begin
                    if (good_cnt + 8'd1 >= ACQ_TARGET) begin
                        state_nxt    = LOCKED;
                        good_cnt_nxt = '0;
                        bad_cnt_nxt  = '0;
                    end else begin
                        good_cnt_nxt = good_cnt + 8'd1;
                    end
                end
            end
            LOCKED: begin
                if (good_frame) begin
                    bad_cnt_nxt = '0;
                end else if (timeout_evt || (bad_frame && (bad_cnt + 8'd1 >= BAD_TARGET))) begin
                    state_nxt   = FAILSAFE;
                    bad_cnt_nxt = '0;
                end else if (bad_frame) begin
                    bad_cnt_nxt = bad_cnt + 8'd1;
                end
            end
            FAILSAFE: begin
                if (good_frame) begin
                    state_nxt    = ACQUIRE;
                    good_cnt_nxt = 8'd1;
                end
            end
            default: begin
                state_nxt    = NO_LINK;
                good_cnt_nxt = '0;
                bad_cnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= NO_LINK;
            good_cnt      <= '0;
            bad_cnt       <= '0;
            frame_err_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
            bad_cnt  <= bad_cnt_nxt;
            if (bad_frame) begin
                frame_err_cnt <= sat_inc8(frame_err_cnt);
            end
        end
    end

    assign reciverenable = (state == LOCKED);
    assign failsafe      = (state == FAILSAFE);
    assign link_state    = state;

endmodule
